fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one my_fifo push port among NUM_REQ producers.
- Each producer has a valid/ready/last interface. The arbiter picks one winner, locks the FIFO to that producer for a multi-beat burst, and drives push/din into the FIFO.
- Never pushes while the FIFO is full. Forces release after MAX_BURST beats so no producer can starve the others.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- WIDTH, 8, data width; must equal the FIFO WIDTH.
- MAX_BURST, 4, maximum accepted beats per grant before forced release (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-producer beat valid
- req_last  in  NUM_REQ  per-producer final beat of burst; qualified by req_valid
- req_data  in  NUM_REQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot-or-zero accept; a beat transfers when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_push  out  1  FIFO push
- fifo_din  out  WIDTH  FIFO write data
- locked  out  1  arbiter is in ARB_LOCKED
- owner  out  $clog2(NUM_REQ)  current/last granted producer index
- burst_trunc  out  1  registered one-cycle pulse on forced release

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: state=ARB_IDLE, rr_ptr=NUM_REQ-1, so producer 0 has top priority first. owner=0, beat_cnt=0, burst_trunc=0.
- Combinational outputs with no latency: req_ready, fifo_push, fifo_din.
  - fifo_push = |(req_valid & req_ready).
  - fifo_din = req_data of the ready index, or 0 when there is no push.
- ARB_IDLE:
  - If fifo_full, req_ready=0.
  - Otherwise winner = first index with req_valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. req_ready[winner]=1.
  - On transfer with req_last=1: stay in IDLE, rr_ptr<=winner, owner<=winner.
  - On transfer with req_last=0: go to ARB_LOCKED, owner<=winner, beat_cnt<=1.
  - If MAX_BURST==1, every beat is treated as last and burst_trunc pulses when req_last=0.
- ARB_LOCKED:
  - req_ready[owner] = !fifo_full. All other readies are 0, even if they are valid.
  - Owner deasserting valid mid-burst: lock held, beat_cnt unchanged, no timeout.
  - fifo_full: lock held, no push.
  - On transfer with req_last=1: go to ARB_IDLE, rr_ptr<=owner, beat_cnt<=0.
  - On transfer where beat_cnt==MAX_BURST-1 and req_last=0: forced release to ARB_IDLE, rr_ptr<=owner, burst_trunc<=1 for exactly one cycle.
  - Otherwise on transfer: beat_cnt<=beat_cnt+1.
- beat_cnt is 4 bits and never exceeds MAX_BURST-1.
- rr_ptr only advances on burst end or release, never on a single idle cycle.
- Invariants (asserted in the bench):
  - $onehot0(req_ready).
  - fifo_full |-> !fifo_push.
  - fifo_push |-> req_valid[owner_or_winner].
  - locked |-> req_ready[j]==0 for all j!=owner.
- Reset mid-burst: lock dropped immediately (async). The partial burst is the producer's responsibility.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined: adds output grant_cnt (NUM_REQ*16 bits). Counter i increments on every accepted beat from producer i, saturates at 16'hFFFF, and resets to 0.
- When undefined: the port and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
  - BEAT_CNT_W=4.
  - STAT_CNT_W=16.
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs are the request vector and rr_ptr; outputs are the winner index and a found flag. It is reused by future read-side arbiters.

Test Plan:
1. Reset, then req_valid=4'b1111 with all req_last=1 and no full → grants in order 0,1,2,3,0; one push per cycle; fifo_din matches each producer's data.
2. Producer 2 sends a 3-beat burst (last on beat 3) while producer 0 is valid throughout → req_ready=4'b0100 for 3 transfers, locked=1 after beat 1, and producer 0 is granted on the next cycle.
3. Producer 1 holds req_last=0 with MAX_BURST=4 → exactly 4 pushes, burst_trunc high for one cycle after the 4th beat, and the next grant goes to another valid producer.
4. fifo_full=1 for 3 cycles mid-burst → fifo_push=0 and req_ready=0 during those cycles; lock and owner are retained; the burst resumes when full drops.
5. Owner drops valid for 2 cycles mid-burst while others are valid → no pushes and no grant changes; beat_cnt is unchanged.
6. Assert rst mid-burst → locked=0 immediately; after release, producer 0 wins first; with FIFO_ARB_STATS_EN, all grant_cnt read 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO write-side arbiter and its helpers.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned BEAT_CNT_W = 4;
  localparam int unsigned STAT_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  logic [N-1:0]   rot;
  logic [IDX_W:0] shamt;
  int unsigned    off;

  // Rotate so bit 0 of rot is the request at ptr+1.
  assign shamt = {1'b0, ptr} + (IDX_W+1)'(1);
  assign rot   = N'({req, req} >> shamt);

  always_comb begin
    found_c = 1'b0;
    off     = 0;
    for (int p = N - 1; p >= 0; p--) begin
      if (rot[p]) begin
        found_c = 1'b1;
        off     = 32'(p);
      end
    end
    idx_c = IDX_W'((32'(ptr) + 32'd1 + off) % N);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO push port among NUM_REQ producers.
// Optional per-producer beat counters on output grant_cnt when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_push,
  output logic [WIDTH-1:0]           fifo_din,
  output logic                       locked,
  output logic [IDX_W-1:0]           owner,
  output logic                       burst_trunc
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_CNT_W-1:0] grant_cnt
`endif
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);

  arb_state_t              state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_found;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .idx_c   (win_idx),
    .found_c (win_found)
  );

  assign locked = (state == ARB_LOCKED);

  // Ready is one-hot-or-zero: the lock owner, else the round-robin winner.
  always_comb begin
    req_ready = '0;
    if (!fifo_full) begin
      if (state == ARB_LOCKED) begin
        req_ready[owner] = 1'b1;
      end else if (win_found) begin
        req_ready[win_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_push = |(req_valid & req_ready);
    fifo_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        fifo_din = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      beat_cnt    <= '0;
      burst_trunc <= 1'b0;
    end else begin
      burst_trunc <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (fifo_push) begin
            owner <= win_idx;
            // A single-beat grant: either a real last beat or a one-beat cap.
            if (req_last[win_idx] || MAX_BURST == 1) begin
              rr_ptr      <= win_idx;
              burst_trunc <= !req_last[win_idx];
            end else begin
              state    <= ARB_LOCKED;
              beat_cnt <= BEAT_CNT_W'(1);
            end
          end
        end
        ARB_LOCKED: begin
          if (fifo_push) begin
            if (req_last[owner] || beat_cnt == LAST_BEAT) begin
              state       <= ARB_IDLE;
              rr_ptr      <= owner;
              beat_cnt    <= '0;
              burst_trunc <= !req_last[owner];
            end else begin
              beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_CNT_W-1:0] stat_q [NUM_REQ];

  // Saturating accepted-beat counters, one per producer.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stat_q[g] <= '0;
      end else if (req_valid[g] && req_ready[g] && stat_q[g] != '1) begin
        stat_q[g] <= stat_q[g] + STAT_CNT_W'(1);
      end
    end
    assign grant_cnt[g*STAT_CNT_W +: STAT_CNT_W] = stat_q[g];
  end
`endif

endmodule
